// File: rtl/x_rams_pipe.sv
// rtl/x_rams_pipe.sv - simple dual-port RAM, one write port, one registered read port
// Optional second output register; collision policy selectable between read-first and write-first.
module x_rams_pipe #(
  parameter int                                WIDTH      = 1,
  parameter int                                ADDR_BITS  = 5,
  parameter logic [WIDTH*(2**ADDR_BITS)-1:0]   INIT       = '0,
  parameter string                             WRITE_MODE = "READ_FIRST",
  parameter int                                DOREG      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wadr,
  input  logic [WIDTH-1:0]     i,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] radr,
  output logic [WIDTH-1:0]     o,
  output logic                 o_vld
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam bit WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("x_rams_pipe: WIDTH must be 1..64");
  end
  if (ADDR_BITS < 4 || ADDR_BITS > 8) begin : g_bad_addr_bits
    $error("x_rams_pipe: ADDR_BITS must be 4..8");
  end
  if (WRITE_MODE != "READ_FIRST" && WRITE_MODE != "WRITE_FIRST") begin : g_bad_write_mode
    $error("x_rams_pipe: WRITE_MODE must be READ_FIRST or WRITE_FIRST");
  end
  if (DOREG != 0 && DOREG != 1) begin : g_bad_doreg
    $error("x_rams_pipe: DOREG must be 0 or 1");
  end

  // Flat word array: word k lives at [k*WIDTH +: WIDTH], matching the INIT layout.
  logic [WIDTH*DEPTH-1:0] mem = INIT;

  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] s1_data;
  logic             s1_vld;
  logic [WIDTH-1:0] s2_data;
  logic             s2_vld;

  always_comb begin
    rd_word = mem[int'(radr)*WIDTH +: WIDTH];
    if (WRITE_FIRST && we && (wadr == radr)) begin
      rd_word = i;
    end
  end

  // The array has no reset branch, so reset only freezes it; read pipeline is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
      s2_data <= '0;
      s2_vld  <= 1'b0;
    end else begin
      if (we) begin
        mem[int'(wadr)*WIDTH +: WIDTH] <= i;
      end
      s1_vld <= re;
      if (re) begin
        s1_data <= rd_word;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_data <= s1_data;
      end
    end
  end

  assign o     = (DOREG != 0) ? s2_data : s1_data;
  assign o_vld = (DOREG != 0) ? s2_vld  : s1_vld;

endmodule

// File: tb/tb_x_rams_pipe.sv
// tb/tb_x_rams_pipe.sv - bench for x_rams_pipe
// Two instances: 256x8 read-first unregistered, 32x8 write-first with output register.
module tb_x_rams_pipe;

  localparam logic [2047:0] INIT_A = 2048'hA5 << 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic       re;
  logic [7:0] wadr;
  logic [7:0] radr;
  logic [7:0] din;
  logic [7:0] o_a;
  logic [7:0] o_b;
  logic       o_vld_a;
  logic       o_vld_b;

  always #5 clk = ~clk;

  x_rams_pipe #(
    .WIDTH(8), .ADDR_BITS(8), .INIT(INIT_A), .WRITE_MODE("READ_FIRST"), .DOREG(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wadr(wadr), .i(din),
    .re(re), .radr(radr), .o(o_a), .o_vld(o_vld_a)
  );

  x_rams_pipe #(
    .WIDTH(8), .ADDR_BITS(5), .WRITE_MODE("WRITE_FIRST"), .DOREG(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wadr(wadr[4:0]), .i(din),
    .re(re), .radr(radr[4:0]), .o(o_b), .o_vld(o_vld_b)
  );

  typedef struct {
    logic       we;
    logic [7:0] wadr;
    logic [7:0] din;
    logic       re;
    logic [7:0] radr;
    logic       vld;
    logic [7:0] o;
  } vec_t;

  vec_t       tbl [14];
  int         checks = 0;
  int         fails  = 0;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [32];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic       va, vb1, vb2;
  logic [7:0] exp_a, exp_b;
  int         nre, nva, nvb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    qa.delete();
    qb.delete();
    va    = 1'b0;
    vb1   = 1'b0;
    vb2   = 1'b0;
    exp_a = 8'h00;
    exp_b = 8'h00;
  endtask

  task automatic check_outputs();
    chk("o_vld_a", o_vld_a, va);
    if (o_vld_a) nva++;
    if (va) begin
      if (qa.size() == 0) begin
        checks++; fails++;
        $display("FAIL qa_underflow: got valid expected no pending read");
      end else exp_a = qa.pop_front();
    end
    chk("o_a", o_a, exp_a);
    chk("o_vld_b", o_vld_b, vb2);
    if (o_vld_b) nvb++;
    if (vb2) begin
      if (qb.size() == 0) begin
        checks++; fails++;
        $display("FAIL qb_underflow: got valid expected no pending read");
      end else exp_b = qb.pop_front();
    end
    chk("o_b", o_b, exp_b);
  endtask

  task automatic cycle(input logic w, input logic [7:0] wa, input logic [7:0] d,
                       input logic r, input logic [7:0] ra);
    @(negedge clk);
    we = w; wadr = wa; din = d; re = r; radr = ra;
    @(posedge clk);
    if (rst_n) begin
      if (r) begin
        qa.push_back(mem_a[ra]);
        qb.push_back((w && wa[4:0] == ra[4:0]) ? d : mem_b[ra[4:0]]);
        nre++;
      end
      if (w) begin
        mem_a[wa]      = d;
        mem_b[wa[4:0]] = d;
      end
      vb2 = vb1;
      vb1 = r;
      va  = r;
    end
    #1 check_outputs();
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd3,   1'b1, 8'hA5};
    tbl[1]  = '{1'b0, 8'd0,   8'h00, 1'b0, 8'd0,   1'b0, 8'hA5};
    tbl[2]  = '{1'b1, 8'd0,   8'h11, 1'b0, 8'd0,   1'b0, 8'hA5};
    tbl[3]  = '{1'b1, 8'd1,   8'h22, 1'b0, 8'd0,   1'b0, 8'hA5};
    tbl[4]  = '{1'b1, 8'd2,   8'h33, 1'b1, 8'd0,   1'b1, 8'h11};
    tbl[5]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd1,   1'b1, 8'h22};
    tbl[6]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd2,   1'b1, 8'h33};
    tbl[7]  = '{1'b0, 8'd0,   8'h00, 1'b0, 8'd0,   1'b0, 8'h33};
    tbl[8]  = '{1'b1, 8'd7,   8'hFF, 1'b1, 8'd7,   1'b1, 8'h00};
    tbl[9]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd7,   1'b1, 8'hFF};
    tbl[10] = '{1'b1, 8'd255, 8'hC3, 1'b0, 8'd0,   1'b0, 8'hFF};
    tbl[11] = '{1'b1, 8'd0,   8'h3C, 1'b1, 8'd255, 1'b1, 8'hC3};
    tbl[12] = '{1'b0, 8'd0,   8'h00, 1'b1, 8'd0,   1'b1, 8'h3C};
    tbl[13] = '{1'b0, 8'd0,   8'h00, 1'b0, 8'd0,   1'b0, 8'h3C};

    for (int k = 0; k < 256; k++) mem_a[k] = 8'h00;
    for (int k = 0; k < 32; k++)  mem_b[k] = 8'h00;
    mem_a[3] = 8'hA5;
    nre = 0; nva = 0; nvb = 0;

    rst_n = 1'b0; we = 1'b0; re = 1'b0; wadr = 8'h00; radr = 8'h00; din = 8'h00;
    reset_model();
    repeat (3) @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed expectations for the unregistered instance
    for (int k = 0; k < 14; k++) begin
      cycle(tbl[k].we, tbl[k].wadr, tbl[k].din, tbl[k].re, tbl[k].radr);
      chk($sformatf("tbl%0d_vld_a", k), o_vld_a, tbl[k].vld);
      chk($sformatf("tbl%0d_o_a", k), o_a, tbl[k].o);
    end
    repeat (2) cycle(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);

    // Read in flight when reset falls, with a write attempted during reset
    cycle(1'b1, 8'd9, 8'h5A, 1'b0, 8'd0);
    cycle(1'b0, 8'd0, 8'h00, 1'b1, 8'd9);
    #2;
    rst_n = 1'b0;
    reset_model();
    #1 check_outputs();
    cycle(1'b1, 8'd9, 8'hEE, 1'b0, 8'd0);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
    cycle(1'b0, 8'd0, 8'h00, 1'b1, 8'd9);
    repeat (2) cycle(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
    chk("reset_read9_a", o_a, 8'h5A);
    chk("reset_read9_b", o_b, 8'h5A);

    // Random traffic with frequent same-address collisions
    nre = 0; nva = 0; nvb = 0;
    for (int n = 0; n < 3000; n++) begin
      logic       w, r;
      logic [7:0] wa, ra, d;
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      wa = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      d  = 8'($urandom);
      cycle(w, wa, d, r, ra);
    end
    repeat (3) cycle(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
    chk("vld_count_a", nva, nre);
    chk("vld_count_b", nvb, nre);
    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
